// File: rtl/multi_lane_serializer.sv
// -----------------------------------------------------------------------------
// multi_lane_serializer
//
// Purpose:
//   Accepts DATA_WIDTH-bit hit words over a valid/ready handshake into a small
//   FIFO and shifts each word out MSB-first across LANES serial lanes. Each
//   lane carries a SEG = DATA_WIDTH/LANES bit slice of the word. Consecutive
//   words are sent back-to-back with no gap cycles. A fixed TEST_PATTERN word
//   can be sent in place of FIFO data. Everything runs on the output clock.
//
// Ports:
//   ClkOut         in   1           serial output clock, rising edge
//   Reset          in   1           synchronous, active-high reset
//   DataIn         in   DATA_WIDTH  word to transmit
//   DataValid      in   1           DataIn valid; accepted when DataReady=1
//   DataReady      out  1           FIFO can accept a word this cycle
//   EnTestPattern  in   1           1: transmit TEST_PATTERN instead of FIFO data
//   DataOut        out  LANES       serial data; lane k = DataIn[DW-1-k*SEG -: SEG]
//   FrameStart     out  1           high during the first bit period of each word
//   Busy           out  1           shifter is transmitting a word
//   WordCount      out  16          words transmitted since reset, wraps
// -----------------------------------------------------------------------------
module multi_lane_serializer #(
  parameter int unsigned           DATA_WIDTH   = 27,
  parameter int unsigned           LANES        = 1,
  parameter int unsigned           FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] TEST_PATTERN = 27'h4AACC0F
) (
  input  logic                  ClkOut,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  DataValid,
  output logic                  DataReady,
  input  logic                  EnTestPattern,
  output logic [LANES-1:0]      DataOut,
  output logic                  FrameStart,
  output logic                  Busy,
  output logic [15:0]           WordCount
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int unsigned SEG   = DATA_WIDTH / LANES;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = (SEG > 1) ? $clog2(SEG) : 1;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if ((DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
      $error("multi_lane_serializer: DATA_WIDTH (%0d) must be a multiple of LANES (%0d)",
             DATA_WIDTH, LANES);
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("multi_lane_serializer: FIFO_DEPTH (%0d) must be a power of 2 and >= 2",
             FIFO_DEPTH);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM state
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_ready;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bitcnt;
  logic                  r_frame_start;
  logic [15:0]           r_word_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_fifo_empty;
  logic                  w_have_src;
  logic                  w_last_bit;
  logic [CNT_W-1:0]      w_count_next;
  logic [DATA_WIDTH-1:0] w_shifted;

  // A push is only honoured while the registered ready is high; Reset has
  // priority so nothing is written on a reset edge.
  assign w_push       = DataValid & r_ready & ~Reset;
  assign w_fifo_empty = (r_count == '0);

  // Something is available to transmit at a load decision.
  assign w_have_src   = EnTestPattern | ~w_fifo_empty;
  assign w_last_bit   = (r_bitcnt == BIT_W'(SEG - 1));

  // Test-pattern loads leave the FIFO untouched, so queued data waits.
  assign w_pop        = w_load & ~EnTestPattern;

  // NOTE: every signal driven in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_have_src) begin
          w_state_next = S_SHIFT;
          w_load       = 1'b1;
        end
      end
      S_SHIFT: begin
        // On the last bit of a word either chain straight into the next
        // word (no gap cycle) or fall back to idle.
        if (w_last_bit) begin
          if (w_have_src) begin
            w_load = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // Shift every lane left by one. The flat shift would carry the MSB of the
  // lower-order lane into the LSB of its neighbour, so each lane's LSB
  // (every multiple of SEG) is forced to zero.
  always_comb begin
    w_shifted = r_shift << 1;
    for (int k = 0; k < int'(LANES); k++) begin
      w_shifted[k*SEG] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge ClkOut) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkOut) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      // Registered ready looks ahead at the post-edge occupancy so it is
      // never high while the FIFO is full.
      r_ready <= (w_count_next < CNT_W'(FIFO_DEPTH));
    end
  end

  // NOTE: the FIFO storage array has no reset; the pointers and count define
  // which entries are valid, and leaving the array unreset lets it map to
  // plain RAM or enable-only flops.
  always_ff @(posedge ClkOut) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter, bit counter, frame marker, word counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge ClkOut) begin
    if (Reset) begin
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_frame_start <= 1'b0;
      r_word_count  <= '0;
    end else if (w_load) begin
      r_shift       <= EnTestPattern ? TEST_PATTERN : r_mem[r_rd_ptr];
      r_bitcnt      <= '0;
      r_frame_start <= 1'b1;
      r_word_count  <= r_word_count + 16'd1;
    end else begin
      r_frame_start <= 1'b0;
      if (r_state == S_SHIFT) begin
        // The shift on the final bit empties every lane, so DataOut reads
        // zero once the FSM is back in idle.
        r_shift  <= w_shifted;
        r_bitcnt <= w_last_bit ? '0 : (r_bitcnt + BIT_W'(1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken straight from flops
  // ---------------------------------------------------------------------------
  always_comb begin
    DataOut = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      DataOut[k] = r_shift[DATA_WIDTH-1-k*SEG];
    end
  end

  assign DataReady  = r_ready;
  assign FrameStart = r_frame_start;
  assign Busy       = (r_state == S_SHIFT);
  assign WordCount  = r_word_count;

endmodule
